spi_frame_deserializer: RTL
===========================

// Module: spi_frame_deserializer
// PURPOSE
//  Parametrised SPI receive front-end for the video/audio data path, running in the CLK_40 domain.
//  - Synchronises the asynchronous SPI_clk_CDC/MISO_CDC pair and detects SPI clock rising edges.
//  - Assembles WORD_W-bit words, groups them into FRAME_WORDS-word frames and tags each frame with
//    a channel id (video/audio/...).
//  - Presents words on a valid/ready interface with overrun and stall-timeout detection.
// PARAMETERS
//  WORD_W       8     bits per word (2..32)
//  FRAME_WORDS  3     words per frame (1..256); 3 x 8 = 24-bit pixel group
//  NUM_CH       2     number of channel tags; CH_W = max(1, $clog2(NUM_CH))
//  SYNC_STAGES  2     synchroniser depth for SPI_clk_CDC and MISO_CDC (>=2)
//  MSB_FIRST    1     1: first received bit lands in word[WORD_W-1]; 0: first bit lands in word[0]
//  TIMEOUT_CYC  4000  CLK_40 cycles without an SPI edge, mid-frame, before abort (100 us)
// PORTS
//  CLK_40        in   1       system clock, 40 MHz
//  reset         in   1       synchronous, active-high
//  SPI_clk_CDC   in   1       asynchronous SPI clock; MISO changes on its falling edge
//  MISO_CDC      in   1       asynchronous serial data
//  chip_select   in   1       active-low frame enable (synchronous to CLK_40)
//  ch_sel        in   CH_W    channel id, sampled at frame start
//  word_data     out  WORD_W  assembled word
//  word_ch       out  CH_W    channel tag of word_data
//  word_last     out  1       word_data is the last word of its frame
//  word_valid    out  1       word_data/word_ch/word_last are valid
//  word_ready    in   1       consumer accepts the word when word_valid & word_ready
//  spi_rise      out  1       single-cycle pulse per synchronised SPI rising edge
//  frame_done    out  1       single-cycle pulse when the final word of a frame is captured
//  overrun       out  1       sticky; cleared only by reset
//  timeout_err   out  1       single-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset:
//  - All outputs are 0, FSM is in IDLE, counters are 0, and all synchroniser flops are 0.
//  - Reset wins over every other event in the same cycle.
//  Synchroniser and edge detect:
//  - SPI_clk_CDC and MISO_CDC pass through identical SYNC_STAGES flop chains.
//  - spi_rise = sclk_s & ~sclk_d. It is a registered output, one cycle after the edge is seen.
//  - The data bit is the MISO_CDC synchroniser output in the same cycle the edge is detected.
//  FSM states:
//  - IDLE: bit_cnt=0 and word_cnt=0. Go to ACTIVE when chip_select==0; ch_sel is latched into ch_q.
//    SPI edges seen in IDLE are ignored.
//  - ACTIVE: each spi_rise shifts one bit in, per MSB_FIRST.
//    - When bit_cnt reaches WORD_W-1 on an edge, go to EMIT on the next cycle.
//    - chip_select rising to 1: discard any partial word and return to IDLE. No error is raised.
//    - Timer reaches TIMEOUT_CYC-1 with no edge: pulse timeout_err, discard any partial word,
//      go to IDLE. The timer is cleared on every edge and on entry to ACTIVE.
//  - EMIT (exactly 1 cycle):
//    - If the output register is empty, or is being accepted this cycle:
//      - load word_data, word_ch=ch_q, word_last=(word_cnt==FRAME_WORDS-1); set word_valid=1.
//      - if the word is last, pulse frame_done, set word_cnt=0 and return to IDLE;
//        otherwise increment word_cnt and return to ACTIVE.
//    - Otherwise set overrun=1, drop the new word, and keep word_cnt moving as above.
//    - spi_rise edges that arrive during EMIT are still shifted in, so no bit is lost.
//  Latency: word_valid rises 2 cycles after the cycle in which the final bit's edge is detected.
//  Output handshake:
//  - word_valid stays high, and word_data is held stable, until word_valid & word_ready.
//  - word_valid drops the cycle after acceptance unless a new word loads in that same cycle.
//  Counter widths:
//  - bit_cnt is $clog2(WORD_W) bits; word_cnt is $clog2(FRAME_WORDS)+1 bits.
//  - Both wrap only through the explicit compares above, never by overflow.
//  Frame boundaries: a new frame never starts without a pass through IDLE. chip_select must
//  return high for at least 1 cycle between frames.
// TESTING
//  1. Reset mid-frame, 4 bits shifted, reset held for 1 cycle -> all outputs 0 next cycle,
//     and the next frame assembles correctly.
//  2. Defaults, MSB_FIRST=1, word_ready=1, 1 MHz SPI with +/-17.5% edge jitter, stream 0xFF,0xBB,0xA0
//     -> word_data 0xFF,0xBB,0xA0; word_last set only on 0xA0; frame_done pulses once.
//  3. MSB_FIRST=0, serial bit order 1,0,0,0,0,0,0,0 -> word_data=0x01.
//  4. word_ready=0 for a full frame -> first word 0xFF held stable, overrun=1 after the 2nd word,
//     0xFF still presented.
//  5. Stop SPI_clk after 5 bits with chip_select low -> timeout_err pulse at 4000 cycles, no
//     word_valid; the next frame 0x00,0xD2,0x00 is received intact.
//  6. Second frame with ch_sel=1 -> word_ch=1 on all 3 words; channel changes mid-frame are ignored.
//  7. Deassert chip_select after 3 bits -> no word, no error pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/spi_frame_deserializer.sv
// SPI receive front-end: synchronises SCLK/MISO into CLK_40, assembles words,
// groups them into channel-tagged frames and presents them on valid/ready.
`timescale 1ns/1ps

module spi_frame_deserializer #(
    parameter int WORD_W      = 8,
    parameter int FRAME_WORDS = 3,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 4000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              SPI_clk_CDC,
    input  logic              MISO_CDC,
    input  logic              chip_select,
    input  logic [CH_W-1:0]   ch_sel,
    output logic [WORD_W-1:0] word_data,
    output logic [CH_W-1:0]   word_ch,
    output logic              word_last,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              spi_rise,
    output logic              frame_done,
    output logic              overrun,
    output logic              timeout_err
);

    // state  | meaning
    // IDLE   | no frame in progress, counters held at 0, waits for chip_select low
    // ACTIVE | shifting bits in on synchronised SCLK rising edges, timeout armed
    // EMIT   | one cycle: hand the completed word to the output register
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_EMIT   = 2'd2;

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int WC_W = $clog2(FRAME_WORDS) + 1;
    localparam int TM_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);
    localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);
    localparam logic [TM_W-1:0] TM_LOAD   = TM_W'(TIMEOUT_CYC - 1);
    localparam logic [TM_W-1:0] TM_ONE    = TM_W'(1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_miso_sync;
    logic                   r_sclk_d;

    logic [1:0]             r_state;
    logic [BC_W-1:0]        r_bit_cnt;
    logic [WC_W-1:0]        r_word_cnt;
    logic [TM_W-1:0]        r_timer;
    logic [WORD_W-1:0]      r_shift;
    logic [CH_W-1:0]        r_ch_q;

    logic [WORD_W-1:0]      r_word_data;
    logic [CH_W-1:0]        r_word_ch;
    logic                   r_word_last;
    logic                   r_word_valid;
    logic                   r_spi_rise;
    logic                   r_frame_done;
    logic                   r_overrun;
    logic                   r_timeout_err;

    logic                   w_sclk_s;
    logic                   w_miso_s;
    logic                   w_edge;
    logic                   w_out_free;
    logic                   w_accept;
    logic                   w_is_last;
    logic [WORD_W-1:0]      w_shift_next;

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_miso_s   = r_miso_sync[SYNC_STAGES-1];
    assign w_edge     = w_sclk_s & ~r_sclk_d;
    assign w_accept   = r_word_valid & word_ready;
    assign w_out_free = ~r_word_valid | word_ready;
    assign w_is_last  = (r_word_cnt == LAST_WORD);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[WORD_W-2:0], w_miso_s};
        end else begin : g_lsb_first
            assign w_shift_next = {w_miso_s, r_shift[WORD_W-1:1]};
        end
    endgenerate

    // Both chains have identical depth so the data bit stays aligned with its clock edge.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_miso_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_clk_CDC};
            r_miso_sync <= {r_miso_sync[SYNC_STAGES-2:0], MISO_CDC};
            r_sclk_d    <= w_sclk_s;
        end
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_timer       <= '0;
            r_shift       <= '0;
            r_ch_q        <= '0;
            r_word_data   <= '0;
            r_word_ch     <= '0;
            r_word_last   <= 1'b0;
            r_word_valid  <= 1'b0;
            r_spi_rise    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_spi_rise    <= w_edge;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            if (w_accept) begin
                r_word_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                    if (!chip_select) begin
                        r_state <= S_ACTIVE;
                        r_ch_q  <= ch_sel;
                        r_timer <= TM_LOAD;
                    end
                end

                S_ACTIVE: begin
                    if (chip_select) begin
                        r_state    <= S_IDLE;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                    end else if (w_edge) begin
                        r_shift <= w_shift_next;
                        r_timer <= TM_LOAD;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_EMIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_ONE;
                        end
                    end else if (r_timer == '0) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                        r_bit_cnt     <= '0;
                        r_word_cnt    <= '0;
                    end else begin
                        r_timer <= r_timer - TM_ONE;
                    end
                end

                S_EMIT: begin
                    // The first bit of the next word may already arrive here; the
                    // load below still sees the completed word from before the shift.
                    r_timer <= TM_LOAD;
                    if (w_edge) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + BC_ONE;
                    end

                    if (w_out_free) begin
                        r_word_data  <= r_shift;
                        r_word_ch    <= r_ch_q;
                        r_word_last  <= w_is_last;
                        r_word_valid <= 1'b1;
                        if (w_is_last) begin
                            r_frame_done <= 1'b1;
                        end
                    end else begin
                        r_overrun <= 1'b1;
                    end

                    if (w_is_last) begin
                        r_word_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_word_cnt <= r_word_cnt + WC_ONE;
                        r_state    <= S_ACTIVE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_bit_cnt  <= '0;
                    r_word_cnt <= '0;
                end
            endcase
        end
    end

    assign word_data   = r_word_data;
    assign word_ch     = r_word_ch;
    assign word_last   = r_word_last;
    assign word_valid  = r_word_valid;
    assign spi_rise    = r_spi_rise;
    assign frame_done  = r_frame_done;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
